// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - writer request/acknowledge bus into vram_arbiter
// Purpose: groups the game-logic writer handshake into one bundle.
// Signals:
//   wr_req  (writer -> arbiter) request, held with wr_addr/wr_data until wr_ack
//   wr_addr (writer -> arbiter) framebuffer write address
//   wr_data (writer -> arbiter) RGB 2-2-2 pixel to write
//   wr_ack  (arbiter -> writer) one-cycle pulse, request taken
//   wr_err  (arbiter -> writer) one-cycle pulse with wr_ack, address out of range
//   wr_busy (arbiter -> writer) write buffer is full
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 6
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              wr_err;
    logic              wr_busy;

    modport master (
        output wr_req, wr_addr, wr_data,
        input  wr_ack, wr_err, wr_busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data,
        output wr_ack, wr_err, wr_busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - pixel RAM port arbiter between scan-out and game-logic writes
// Purpose: display reads own the RAM port during active video; writes wait in a
// one-entry buffer and drain only when the port is free in blanking. Also emits
// the RGB pixel and syncs, delayed three stages so they stay aligned.
// Ports:
//   clk, reset                      pixel clock, async active-high reset
//   col_count, row_count, valid     timing generator position and active-area flag
//   hsync_in, vsync_in              raw active-low syncs
//   pix_data, pix_valid             pixel to the DAC and its valid flag
//   hsync_out, vsync_out            syncs aligned with pix_data
//   wr                              writer bus (slave side)
//   mem_addr, mem_we, mem_wdata     single-port RAM command
//   mem_rdata                       RAM read data, one cycle after mem_addr
module vram_arbiter #(
    parameter int FB_W   = 160,
    parameter int FB_H   = 120,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        col_count,
    input  logic [9:0]        row_count,
    input  logic              valid,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              hsync_out,
    output logic              vsync_out,
    vram_arbiter_if.slave     wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] FB_LIMIT = (ADDR_W + 1)'(FB_W * FB_H);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    logic [ADDR_W-1:0] row_fb;
    logic [ADDR_W-1:0] col_fb;
    logic [ADDR_W-1:0] row_term;
    logic              addr_oob;

    state_t            state_d,     state_q;
    logic [ADDR_W-1:0] buf_addr_d,  buf_addr_q;
    logic [DATA_W-1:0] buf_data_d,  buf_data_q;
    logic              wr_ack_d,    wr_ack_q;
    logic              wr_err_d,    wr_err_q;
    logic              mem_we_d,    mem_we_q;
    logic [ADDR_W-1:0] disp_addr_d, disp_addr_q;
    logic              v1_d,  v1_q,  v2_d,  v2_q;
    logic              hs1_d, hs1_q, hs2_d, hs2_q;
    logic              vs1_d, vs1_q, vs2_d, vs2_q;
    logic [DATA_W-1:0] pix_data_d,  pix_data_q;
    logic              pix_valid_d, pix_valid_q;
    logic              hsync_out_d, hsync_out_q;
    logic              vsync_out_d, vsync_out_q;

    // Each framebuffer pixel covers 4x4 screen pixels.
    assign row_fb = ADDR_W'(row_count[9:2]);
    assign col_fb = ADDR_W'(col_count[9:2]);

    generate
        if (FB_W == 160) begin : g_row_160
            assign row_term = (row_fb << 7) + (row_fb << 5);
        end else begin : g_row_gen
            assign row_term = row_fb * ADDR_W'(FB_W);
        end
    endgenerate

    assign addr_oob = {1'b0, wr.wr_addr} >= FB_LIMIT;

    always_comb begin
        disp_addr_d = row_term + col_fb;
        v1_d        = valid;
        hs1_d       = hsync_in;
        vs1_d       = vsync_in;
        v2_d        = v1_q;
        hs2_d       = hs1_q;
        vs2_d       = vs1_q;
        // Blanking is forced black regardless of what the RAM returned.
        pix_data_d  = v2_q ? mem_rdata : '0;
        pix_valid_d = v2_q;
        hsync_out_d = hs2_q;
        vsync_out_d = vs2_q;

        state_d    = state_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        wr_ack_d   = 1'b0;
        wr_err_d   = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                // The writer may still hold wr_req during the ack cycle, so
                // that cycle must not be taken as a second request.
                if (wr.wr_req && !wr_ack_q) begin
                    wr_ack_d = 1'b1;
                    if (addr_oob) begin
                        wr_err_d = 1'b1;
                    end else begin
                        buf_addr_d = wr.wr_addr;
                        buf_data_d = wr.wr_data;
                        state_d    = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                // valid now is v1 next cycle: the drain cycle is guaranteed
                // to be a cycle where the display does not own the port.
                if (!valid) begin
                    mem_we_d = 1'b1;
                    state_d  = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            wr_ack_q    <= 1'b0;
            wr_err_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            disp_addr_q <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            hs1_q       <= 1'b1;
            hs2_q       <= 1'b1;
            vs1_q       <= 1'b1;
            vs2_q       <= 1'b1;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            hsync_out_q <= 1'b1;
            vsync_out_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            wr_ack_q    <= wr_ack_d;
            wr_err_q    <= wr_err_d;
            mem_we_q    <= mem_we_d;
            disp_addr_q <= disp_addr_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            hs1_q       <= hs1_d;
            hs2_q       <= hs2_d;
            vs1_q       <= vs1_d;
            vs2_q       <= vs2_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
        end
    end

    assign mem_addr   = v1_q ? disp_addr_q : buf_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = buf_data_q;
    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign hsync_out  = hsync_out_q;
    assign vsync_out  = vsync_out_q;
    assign wr.wr_ack  = wr_ack_q;
    assign wr.wr_err  = wr_err_q;
    assign wr.wr_busy = (state_q == ST_FULL);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
module tb_vram_arbiter;
    localparam int FB_SIZE = 19200;
    localparam int RCYC    = 3000;
    localparam int NVEC    = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] col_count, row_count;
    logic       valid, hsync_in, vsync_in;
    logic [5:0] pix_data;
    logic       pix_valid, hsync_out, vsync_out;
    logic [14:0] mem_addr;
    logic       mem_we;
    logic [5:0] mem_wdata, mem_rdata;

    vram_arbiter_if #(.ADDR_W(15), .DATA_W(6)) wr_if ();

    vram_arbiter #(.FB_W(160), .FB_H(120), .ADDR_W(15), .DATA_W(6)) dut (
        .clk(clk), .reset(reset),
        .col_count(col_count), .row_count(row_count), .valid(valid),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .wr(wr_if.slave),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-first, preloaded with addr[5:0].
    logic [5:0] ram [0:32767];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 32768; i++) ram[i] = 6'(i);
            ram_init = 1'b1;
        end
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    int checks = 0;
    int errors = 0;
    logic [5:0] shadow [0:32767];

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic        v;
        logic        hs;
        logic        vs;
        logic [14:0] exp_addr;
        logic [5:0]  exp_pix;
    } vec_t;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; col_count = 10'd700; row_count = 10'd0;
        hsync_in = 1'b1; vsync_in = 1'b1;
    endtask

    task automatic req(input int a, input int d);
        wr_if.wr_req = 1'b1; wr_if.wr_addr = 15'(a); wr_if.wr_data = 6'(d);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pix_data"},  pix_data,  0);
        chk({tag, " pix_valid"}, pix_valid, 0);
        chk({tag, " hsync_out"}, hsync_out, 1);
        chk({tag, " vsync_out"}, vsync_out, 1);
        chk({tag, " wr_ack"},    wr_if.wr_ack,  0);
        chk({tag, " wr_err"},    wr_if.wr_err,  0);
        chk({tag, " wr_busy"},   wr_if.wr_busy, 0);
        chk({tag, " mem_we"},    mem_we,    0);
        chk({tag, " mem_addr"},  mem_addr,  0);
        chk({tag, " mem_wdata"}, mem_wdata, 0);
    endtask

    function automatic int disp(input int r, input int c);
        return ((r / 4) * 160 + c / 4) % 32768;
    endfunction

    // Random-phase history and model state
    logic hv [0:RCYC-1];
    logic hhs [0:RCYC-1];
    logic hvs [0:RCYC-1];
    int   haddr [0:RCYC-1];
    logic [5:0] hval [0:RCYC-1];

    initial begin
        int we_cnt;
        int bad_we;
        int m_out;
        logic m_ack_prev, exp_ack, exp_we, d_req;
        logic [14:0] m_baddr, d_addr;
        logic [5:0]  m_bdata, d_data;
        int run_left, req_age;
        logic [5:0] exp_pix;

        tbl[0] = '{row: 10'd8,   col: 10'd12,  v: 1'b1, hs: 1'b1, vs: 1'b1, exp_addr: 15'd323,   exp_pix: 6'd3};
        tbl[1] = '{row: 10'd0,   col: 10'd0,   v: 1'b1, hs: 1'b0, vs: 1'b1, exp_addr: 15'd0,     exp_pix: 6'd0};
        tbl[2] = '{row: 10'd479, col: 10'd639, v: 1'b1, hs: 1'b1, vs: 1'b0, exp_addr: 15'd19199, exp_pix: 6'd63};
        tbl[3] = '{row: 10'd4,   col: 10'd4,   v: 1'b1, hs: 1'b1, vs: 1'b1, exp_addr: 15'd161,   exp_pix: 6'd33};
        tbl[4] = '{row: 10'd8,   col: 10'd700, v: 1'b0, hs: 1'b0, vs: 1'b1, exp_addr: 15'd0,     exp_pix: 6'd0};
        tbl[5] = '{row: 10'd100, col: 10'd300, v: 1'b1, hs: 1'b1, vs: 1'b1, exp_addr: 15'd4075,  exp_pix: 6'd43};
        tbl[6] = '{row: 10'd500, col: 10'd12,  v: 1'b0, hs: 1'b1, vs: 1'b0, exp_addr: 15'd0,     exp_pix: 6'd0};
        for (int i = 0; i < 32768; i++) shadow[i] = 6'(i);

        // Asynchronous reset: outputs must clear without a clock edge.
        reset = 1'b0; idle();
        wr_if.wr_req = 1'b0; wr_if.wr_addr = '0; wr_if.wr_data = '0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("por");
        tick(); tick();
        reset = 1'b0;
        tick(); tick();

        // Scan-out vectors: mem_addr one cycle after sampling, pixel and syncs three.
        for (int i = 0; i < NVEC + 2; i++) begin
            if (i < NVEC) begin
                row_count = tbl[i].row; col_count = tbl[i].col; valid = tbl[i].v;
                hsync_in = tbl[i].hs; vsync_in = tbl[i].vs;
            end else begin
                idle();
            end
            tick();
            if (i < NVEC && tbl[i].v) chk($sformatf("vec%0d mem_addr", i), mem_addr, tbl[i].exp_addr);
            if (i >= 2) begin
                chk($sformatf("vec%0d pix_data", i - 2),  pix_data,  tbl[i-2].exp_pix);
                chk($sformatf("vec%0d pix_valid", i - 2), pix_valid, tbl[i-2].v);
                chk($sformatf("vec%0d hsync_out", i - 2), hsync_out, tbl[i-2].hs);
                chk($sformatf("vec%0d vsync_out", i - 2), vsync_out, tbl[i-2].vs);
            end
        end

        // Blanking write, then read it back on screen.
        idle(); req(100, 'h2A);
        tick();
        chk("blank ack", wr_if.wr_ack, 1); chk("blank err", wr_if.wr_err, 0);
        chk("blank busy", wr_if.wr_busy, 1); chk("blank we early", mem_we, 0);
        wr_if.wr_req = 1'b0;
        tick();
        chk("blank we", mem_we, 1); chk("blank addr", mem_addr, 100);
        chk("blank wdata", mem_wdata, 'h2A); chk("blank busy after", wr_if.wr_busy, 0);
        shadow[100] = 6'h2A;
        tick();
        chk("blank we once", mem_we, 0);
        row_count = 10'd0; col_count = 10'd400; valid = 1'b1;
        tick(); idle(); tick(); tick();
        chk("readback pix", pix_data, 'h2A);

        // Write during active video plus a second request while full.
        valid = 1'b1; row_count = 10'd0; col_count = 10'd10; req(500, 'h11);
        tick();
        chk("active ack", wr_if.wr_ack, 1); chk("active busy", wr_if.wr_busy, 1);
        wr_if.wr_req = 1'b0;
        we_cnt = 0; bad_we = 0;
        for (int i = 0; i < 20; i++) begin
            col_count = 10'(14 + 4 * i);
            if (i == 5) req(600, 'h22);
            tick();
            if (mem_we) we_cnt++;
            if (wr_if.wr_ack) bad_we++;
        end
        chk("active no we", we_cnt, 0);
        chk("full no ack", bad_we, 0);
        chk("full busy held", wr_if.wr_busy, 1);
        idle();
        tick();
        chk("drain we", mem_we, 1); chk("drain addr", mem_addr, 500); chk("drain data", mem_wdata, 'h11);
        chk("drain no ack", wr_if.wr_ack, 0);
        tick();
        chk("b2b ack", wr_if.wr_ack, 1); chk("b2b no we", mem_we, 0);
        wr_if.wr_req = 1'b0;
        tick();
        chk("b2b we", mem_we, 1); chk("b2b addr", mem_addr, 600); chk("b2b data", mem_wdata, 'h22);
        shadow[500] = 6'h11; shadow[600] = 6'h22;

        // Out-of-range and last in-range address.
        tick(); req(FB_SIZE, 'h01);
        tick();
        chk("oob ack", wr_if.wr_ack, 1); chk("oob err", wr_if.wr_err, 1); chk("oob busy", wr_if.wr_busy, 0);
        wr_if.wr_req = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (mem_we) we_cnt++; end
        chk("oob no we", we_cnt, 0);
        req(FB_SIZE - 1, 'h05);
        tick();
        chk("last ack", wr_if.wr_ack, 1); chk("last err", wr_if.wr_err, 0);
        wr_if.wr_req = 1'b0;
        tick();
        chk("last we", mem_we, 1); chk("last addr", mem_addr, FB_SIZE - 1);
        shadow[FB_SIZE-1] = 6'h05;
        tick();

        // Reset while full in active video; a request held across reset is retaken.
        valid = 1'b1; row_count = 10'd20; col_count = 10'd40; hsync_in = 1'b0; req(300, 'h3F);
        tick();
        chk("rst full ack", wr_if.wr_ack, 1);
        wr_if.wr_req = 1'b0;
        tick(); tick(); tick();
        chk("rst pre pix_valid", pix_valid, 1); chk("rst pre hsync", hsync_out, 0);
        #2 reset = 1'b1; idle(); req(200, 'h15);
        #1 chk_reset_vals("midrst");
        bad_we = 0; we_cnt = 0;
        tick(); if (mem_we) bad_we++;
        tick(); if (mem_we) bad_we++;
        reset = 1'b0;
        tick();
        chk("held req ack", wr_if.wr_ack, 1);
        wr_if.wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_we && mem_addr == 15'd300) bad_we++;
            if (mem_we && mem_addr == 15'd200) we_cnt++;
        end
        chk("discarded entry", bad_we, 0);
        chk("held req written", we_cnt, 1);
        chk("busy after rst", wr_if.wr_busy, 0);
        shadow[200] = 6'h15;

        // Randomized traffic against the reference model.
        idle(); tick(); tick();
        m_out = 0; m_ack_prev = 1'b0; m_baddr = '0; m_bdata = '0;
        run_left = 0; req_age = 0;
        for (int k = 0; k < RCYC; k++) begin
            if (run_left == 0) begin valid = ~valid; run_left = $urandom_range(1, 40); end
            run_left--;
            if (valid) begin
                row_count = 10'($urandom_range(0, 479)); col_count = 10'($urandom_range(0, 639));
            end else begin
                row_count = 10'($urandom_range(0, 524)); col_count = 10'($urandom_range(640, 799));
            end
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            if (!wr_if.wr_req && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 7))
                    0:       req($urandom_range(FB_SIZE, 32767), $urandom);
                    1:       req(FB_SIZE - 1, $urandom);
                    default: req($urandom_range(0, FB_SIZE - 1), $urandom);
                endcase
            end
            hv[k] = valid; hhs[k] = hsync_in; hvs[k] = vsync_in;
            haddr[k] = disp(int'(row_count), int'(col_count));
            d_req = wr_if.wr_req; d_addr = wr_if.wr_addr; d_data = wr_if.wr_data;
            tick();

            exp_ack = d_req && (m_out == 0) && !m_ack_prev;
            exp_we  = (m_out != 0) && !valid;
            chk("rnd ack", wr_if.wr_ack, exp_ack);
            chk("rnd err", wr_if.wr_err, exp_ack && (int'(d_addr) >= FB_SIZE));
            chk("rnd we", mem_we, exp_we);
            if (k >= 1) hval[k-1] = shadow[haddr[k-1]];
            if (exp_we && mem_we) begin
                chk("rnd we addr", mem_addr, m_baddr);
                chk("rnd we data", mem_wdata, m_bdata);
            end
            if (exp_we) begin shadow[m_baddr] = m_bdata; m_out = 0; end
            if (exp_ack && int'(d_addr) < FB_SIZE) begin m_out = 1; m_baddr = d_addr; m_bdata = d_data; end
            m_ack_prev = exp_ack;
            chk("rnd busy", wr_if.wr_busy, m_out);
            if (valid) chk("rnd disp addr", mem_addr, haddr[k]);
            if (k >= 2) begin
                exp_pix = hv[k-2] ? hval[k-2] : 6'd0;
                chk("rnd pix", pix_data, exp_pix);
                chk("rnd pix_valid", pix_valid, hv[k-2]);
                chk("rnd hsync", hsync_out, hhs[k-2]);
                chk("rnd vsync", vsync_out, hvs[k-2]);
            end
            if (wr_if.wr_ack) begin
                wr_if.wr_req = 1'b0; req_age = 0;
            end else if (wr_if.wr_req) begin
                req_age++;
                if (req_age > 500) begin
                    checks++; errors++;
                    $display("FAIL rnd ack timeout actual=%0d required=%0d", req_age, 500);
                    wr_if.wr_req = 1'b0; req_age = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
